// File: rtl/hazard_pkg.sv
// Shared encodings for the execute-stage hazard/forwarding controller.
// Writeback sources, FSM states and forwarding control-word bit positions.
package hazard_pkg;

  localparam logic [1:0] WB_ADDPC = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_ALU   = 2'b10;
  localparam logic [1:0] WB_IMM8  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  localparam int FW_W   = 5;
  localparam int FW_STU = 4;
  localparam int FW_EN  = 3;
  localparam int FW_MEM = 2;
  localparam int FW_SRC = 0;

  function automatic logic [FW_W-1:0] fw_word(input logic       stu,
                                              input logic       en,
                                              input logic       mem,
                                              input logic [1:0] src);
    logic [FW_W-1:0] w;
    w               = '0;
    w[FW_STU]       = stu;
    w[FW_EN]        = en;
    w[FW_MEM]       = mem;
    w[FW_SRC +: 2]  = src;
    return w;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Operand compare against the EX and MEM writers; builds one forwarding word.
// Purely combinational; hit flags a match on the EX-stage writer (load-use candidate).
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic             id_valid,
  input  logic             src_used,
  input  logic [REG_W-1:0] src_reg,
  input  logic             stu,
  input  logic             ex_valid,
  input  logic             ex_wr_en,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic [1:0]       ex_wb_sel,
  input  logic             mem_valid,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] mem_wr_reg,
  input  logic [1:0]       mem_wb_sel,
  output logic             hit,
  output logic [FW_W-1:0]  word
);

  logic ex_m;
  logic mem_m;

  assign ex_m  = id_valid & src_used & ex_valid  & ex_wr_en  & (ex_wr_reg  == src_reg);
  assign mem_m = id_valid & src_used & mem_valid & mem_wr_en & (mem_wr_reg == src_reg);
  assign hit   = ex_m;

  // The younger producer (EX) wins when both stages write the same register.
  always_comb begin
    word = fw_word(stu, 1'b0, 1'b0, WB_ADDPC);
    if (ex_m) begin
      word = fw_word(stu, 1'b1, 1'b0, ex_wb_sel);
    end else if (mem_m) begin
      word = fw_word(stu, 1'b1, 1'b1, mem_wb_sel);
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Execute-stage hazard controller: writer tracker, registered fwCntrlA/B, load-use stall, mispredict flush.
// Control words registered as the instruction enters EX; stall/bubble/flush are combinational. EX_FWD_EN enables EX->EX forwarding.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_stu_sel,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [1:0]       id_wb_sel,
  input  logic             branch_misprediction,
  output logic [FW_W-1:0]  fwCntrlA,
  output logic [FW_W-1:0]  fwCntrlB,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id
);

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic [1:0]       wb_sel;
  } ent_t;

  ent_t            ex_ent;
  ent_t            mem_ent;
  ent_t            id_ent;
  state_t          state;
  state_t          state_nxt;
  logic            hit_a;
  logic            hit_b;
  logic [FW_W-1:0] word_a;
  logic [FW_W-1:0] word_b;
  logic            lu_a;
  logic            lu_b;
  logic            load_use;

  assign id_ent = '{valid: id_valid, wr_en: id_wr_en, wr_reg: id_wr_reg, wb_sel: id_wb_sel};

  fwd_match #(.REG_W(REG_W)) u_match_a (
    .id_valid   (id_valid),
    .src_used   (id_rs_used),
    .src_reg    (id_rs),
    .stu        (1'b0),
    .ex_valid   (ex_ent.valid),
    .ex_wr_en   (ex_ent.wr_en),
    .ex_wr_reg  (ex_ent.wr_reg),
    .ex_wb_sel  (ex_ent.wb_sel),
    .mem_valid  (mem_ent.valid),
    .mem_wr_en  (mem_ent.wr_en),
    .mem_wr_reg (mem_ent.wr_reg),
    .mem_wb_sel (mem_ent.wb_sel),
    .hit        (hit_a),
    .word       (word_a)
  );

  fwd_match #(.REG_W(REG_W)) u_match_b (
    .id_valid   (id_valid),
    .src_used   (id_rt_used),
    .src_reg    (id_rt),
    .stu        (id_stu_sel),
    .ex_valid   (ex_ent.valid),
    .ex_wr_en   (ex_ent.wr_en),
    .ex_wr_reg  (ex_ent.wr_reg),
    .ex_wb_sel  (ex_ent.wb_sel),
    .mem_valid  (mem_ent.valid),
    .mem_wr_en  (mem_ent.wr_en),
    .mem_wr_reg (mem_ent.wr_reg),
    .mem_wb_sel (mem_ent.wb_sel),
    .hit        (hit_b),
    .word       (word_b)
  );

`ifdef EX_FWD_EN
  // Only load data is unavailable at the end of EX.
  assign lu_a = hit_a & (ex_ent.wb_sel == WB_MEM);
  assign lu_b = hit_b & (ex_ent.wb_sel == WB_MEM);
`else
  assign lu_a = hit_a;
  assign lu_b = hit_b;
`endif

  assign load_use = lu_a | lu_b;

  always_comb begin
    state_nxt   = state;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    case (state)
      ST_RUN: begin
        if (load_use) begin
          state_nxt   = ST_LDSTALL;
          stall_if_id = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      ST_LDSTALL: state_nxt = ST_RUN;
      ST_FLUSH:   state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
    // A misprediction squashes the stalled consumer too, so the stall is dropped.
    if (branch_misprediction) begin
      state_nxt   = ST_FLUSH;
      stall_if_id = 1'b0;
      bubble_ex   = 1'b1;
      flush_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      ex_ent   <= '0;
      mem_ent  <= '0;
      fwCntrlA <= '0;
      fwCntrlB <= '0;
    end else begin
      state    <= state_nxt;
      mem_ent  <= ex_ent;
      ex_ent   <= bubble_ex ? '0 : id_ent;
      fwCntrlA <= bubble_ex ? '0 : word_a;
      fwCntrlB <= bubble_ex ? '0 : word_b;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed plus random checks of hazard_fwd_ctrl against a pipeline-history reference model.
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       id_stu_sel;
  logic       id_wr_en;
  logic [2:0] id_wr_reg;
  logic [1:0] id_wb_sel;
  logic       branch_misprediction;
  logic [4:0] fwCntrlA;
  logic [4:0] fwCntrlB;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       flush_if_id;

  hazard_fwd_ctrl #(.REG_W(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_valid             (id_valid),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_rs_used           (id_rs_used),
    .id_rt_used           (id_rt_used),
    .id_stu_sel           (id_stu_sel),
    .id_wr_en             (id_wr_en),
    .id_wr_reg            (id_wr_reg),
    .id_wb_sel            (id_wb_sel),
    .branch_misprediction (branch_misprediction),
    .fwCntrlA             (fwCntrlA),
    .fwCntrlB             (fwCntrlB),
    .stall_if_id          (stall_if_id),
    .bubble_ex            (bubble_ex),
    .flush_if_id          (flush_if_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hist[0] is the instruction now in EX, hist[1] the one now in MEM.
  typedef struct {
    bit       v;
    bit       we;
    bit [2:0] rd;
    bit [1:0] wb;
  } rec_t;

  rec_t hist[2];
  int   checks = 0;
  int   errors = 0;

  task automatic chk5(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Search producers oldest first so the youngest matching one is what remains.
  function automatic bit [4:0] model_word(bit is_b, bit used, bit [2:0] r);
    bit [4:0] w;
    w = 5'b0;
    if (is_b) w[4] = id_stu_sel;
    if (id_valid && used) begin
      for (int age = 1; age >= 0; age--) begin
        if (hist[age].v && hist[age].we && hist[age].rd == r) begin
          w[3]   = 1'b1;
          w[2]   = (age == 1);
          w[1:0] = hist[age].wb;
        end
      end
    end
    return w;
  endfunction

  function automatic bit model_lu(bit used, bit [2:0] r);
    if (!(id_valid && used && hist[0].v && hist[0].we && hist[0].rd == r)) return 1'b0;
`ifdef EX_FWD_EN
    return hist[0].wb == 2'b01;
`else
    return 1'b1;
`endif
  endfunction

  task automatic cycle(output bit stalled);
    bit [4:0] ea;
    bit [4:0] eb;
    bit       lu;
    bit       mis;
    bit       bub;
    @(negedge clk);
    ea  = model_word(1'b0, id_rs_used, id_rs);
    eb  = model_word(1'b1, id_rt_used, id_rt);
    lu  = model_lu(id_rs_used, id_rs) | model_lu(id_rt_used, id_rt);
    mis = branch_misprediction;
    bub = lu | mis;
    chk1("stall_if_id", stall_if_id, lu & ~mis);
    chk1("bubble_ex", bubble_ex, bub);
    chk1("flush_if_id", flush_if_id, mis);
    @(posedge clk);
    #1;
    if (rst) begin
      hist[0] = '{v: 0, we: 0, rd: 0, wb: 0};
      hist[1] = '{v: 0, we: 0, rd: 0, wb: 0};
      ea = 5'b0;
      eb = 5'b0;
    end else begin
      hist[1] = hist[0];
      if (bub) begin
        hist[0] = '{v: 0, we: 0, rd: 0, wb: 0};
        ea = 5'b0;
        eb = 5'b0;
      end else begin
        hist[0] = '{v: id_valid, we: id_wr_en, rd: id_wr_reg, wb: id_wb_sel};
      end
    end
    chk5("fwCntrlA", fwCntrlA, ea);
    chk5("fwCntrlB", fwCntrlB, eb);
    stalled = lu & ~mis & ~rst;
  endtask

  task automatic drive(bit v, bit [2:0] rs, bit rsu, bit [2:0] rt, bit rtu, bit stu,
                       bit we, bit [2:0] wd, bit [1:0] wb, bit mis);
    id_valid             = v;
    id_rs                = rs;
    id_rs_used           = rsu;
    id_rt                = rt;
    id_rt_used           = rtu;
    id_stu_sel           = stu;
    id_wr_en             = we;
    id_wr_reg            = wd;
    id_wb_sel            = wb;
    branch_misprediction = mis;
  endtask

  // One decode instruction, held in decode for as long as it is stalled.
  task automatic issue(bit v, bit [2:0] rs, bit rsu, bit [2:0] rt, bit rtu, bit stu,
                       bit we, bit [2:0] wd, bit [1:0] wb, bit mis);
    bit st;
    drive(v, rs, rsu, rt, rtu, stu, we, wd, wb, mis);
    cycle(st);
    branch_misprediction = 1'b0;
    for (int k = 0; k < 3 && st; k++) cycle(st);
    chk1("stall_bound", st, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    bit prev_st;
    bit prev_mis;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(st);
    cycle(st);
    chk5("rst_fwA", fwCntrlA, 5'b0);
    chk5("rst_fwB", fwCntrlB, 5'b0);
    chk1("rst_stall", stall_if_id, 1'b0);
    rst = 1'b0;

    // ALU producer, back-to-back consumer on rs
    issue(1, 3'd5, 1, 3'd6, 1, 0, 1, 3'd1, 2'b10, 0);
    issue(1, 3'd1, 1, 3'd7, 0, 0, 0, 3'd0, 2'b10, 0);
    // LBI producer, gap, consumer on rt
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd2, 2'b11, 0);
    issue(1, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 2'b10, 0);
    issue(1, 3'd6, 0, 3'd2, 1, 0, 1, 3'd7, 2'b10, 0);
    // load-use on rs
    issue(1, 3'd0, 1, 3'd0, 0, 0, 1, 3'd3, 2'b01, 0);
    issue(1, 3'd3, 1, 3'd5, 1, 0, 1, 3'd5, 2'b10, 0);
    // store data from preceding ALU write
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd4, 2'b10, 0);
    issue(1, 3'd6, 1, 3'd4, 1, 1, 0, 3'd0, 2'b00, 0);
    // load-use together with a misprediction
    issue(1, 3'd0, 1, 3'd0, 0, 0, 1, 3'd5, 2'b01, 0);
    issue(1, 3'd5, 1, 3'd5, 1, 0, 1, 3'd1, 2'b10, 1);
    issue(0, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 2'b00, 0);
    issue(1, 3'd1, 1, 3'd2, 1, 0, 1, 3'd3, 2'b00, 0);

    // reset while the load-use stall is in progress
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd6, 2'b01, 0);
    drive(1, 3'd6, 1, 3'd0, 0, 0, 0, 3'd0, 2'b10, 0);
    cycle(st);
    chk1("stall_entered", st, 1'b1);
    rst = 1'b1;
    cycle(st);
    rst = 1'b0;
    chk5("rst_mid_fwA", fwCntrlA, 5'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    cycle(st);
    chk1("rst_mid_stall", stall_if_id, 1'b0);
    chk1("rst_mid_bubble", bubble_ex, 1'b0);
    issue(1, 3'd6, 1, 3'd6, 1, 0, 0, 3'd0, 2'b00, 0);

    // random traffic on a small register set to provoke dependencies
    prev_st  = 1'b0;
    prev_mis = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!prev_st) begin
        drive(prev_mis ? 1'b0 : ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
              2'($urandom), 1'b0);
      end
      branch_misprediction = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      prev_mis = branch_misprediction;
      cycle(st);
      prev_st = st;
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller for the execute stage: tracks in-flight register writers in EX and MEM, generates the registered 5-bit forwarding control words consumed by execute, and detects load-use hazards. It inserts stalls and bubbles, and squashes the wrong-path instructions on a branch misprediction. It sits beside the ID/EX pipeline register. Decode-stage operand info enters it; fwCntrlA/fwCntrlB leave it aligned with the instruction entering EX.

## Interface
Parameters:
- REG_W, 3, register specifier width (8 GPRs, all forwardable, no hardwired zero)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs / id_rt  in  REG_W  source specifiers
- id_rs_used / id_rt_used  in  1  operand is read
- id_stu_sel  in  1  store/STU: rt is store data, not ALU B
- id_wr_en  in  1  decode instruction writes a register
- id_wr_reg  in  REG_W  destination
- id_wb_sel  in  2  writeback source: 00 addPC, 01 mem, 10 ALU, 11 imm8
- branch_misprediction  in  1  from execute, taken branch in EX
- fwCntrlA / fwCntrlB  out  5  forwarding control words to execute
- stall_if_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  zero ID/EX control fields
- flush_if_id  out  1  invalidate IF/ID

## Operation
- Control word format:
  - [4] stuSel (B only; A[4]=0)
  - [3] forward enable
  - [2] 0 for EX→EX, 1 for MEM→EX
  - [1:0] source, equal to the producer's wb_sel
- Tracker: two registered entries.
  - ex_ent holds the instruction now in EX; mem_ent holds the one now in MEM.
  - Each entry holds {valid, wr_en, wr_reg, wb_sel}.
  - Every cycle mem_ent <= ex_ent.
  - ex_ent <= decode info if the instruction advances, else invalid.
- Match for operand X (rs→A, rt→B) = id_valid & X_used & entry.valid & entry.wr_en & entry.wr_reg==X.
  - ex_ent match: word = {stu,1,0,ex_ent.wb_sel}.
  - Otherwise mem_ent match: word = {stu,1,1,mem_ent.wb_sel}.
  - Otherwise {stu,0,0,00}.
  - ex_ent takes priority over mem_ent.
  - stu = id_stu_sel for B only.
- Load-use: an ex_ent match with wb_sel==01 forces a one-cycle stall. Memory data cannot be forwarded EX→EX.
- FSM states: RUN, LDSTALL, FLUSH.
  - RUN → LDSTALL on a load-use hazard. Assert stall_if_id and bubble_ex; ex_ent loads invalid.
  - LDSTALL → RUN unconditionally. The producer is now in MEM and is forwarded with [2:0]=1,01.
  - Any state → FLUSH on branch_misprediction. Assert flush_if_id and bubble_ex; ex_ent loads invalid.
  - FLUSH → RUN next cycle.
- Simultaneous events:
  - Misprediction overrides a load-use stall; the stall is dropped.
  - A second load-use in LDSTALL's following cycle is evaluated normally from RUN.
- Reset: ex_ent/mem_ent invalid, state RUN, fwCntrlA/B=5'b0, stall_if_id=bubble_ex=flush_if_id=0.
- Reset mid-stall returns to RUN with no pending bubble.

## Timing
- fwCntrlA/B are registered and update on the edge that moves the decode instruction into EX. Execute sees them with zero added latency.
- On a bubble edge fwCntrlA/B load 5'b0.
- stall_if_id, bubble_ex and flush_if_id are combinational from decode inputs, tracker and branch_misprediction. They act on the next edge.
- Load-use penalty: exactly 1 cycle. Misprediction penalty: 2 instructions squashed (IF/ID and ID/EX) in one cycle.
- No path from fwCntrl outputs back to inputs; there is no combinational loop with execute.

## Configuration
- EX_FWD_EN defined: EX→EX forwarding as above.
- EX_FWD_EN undefined:
  - Any ex_ent match, regardless of wb_sel, takes the LDSTALL path.
  - The operand is then forwarded MEM→EX.
  - Control words never have [3:2]=10.

## Structure
- Shared package hazard_pkg holds:
  - WB_ADDPC/WB_MEM/WB_ALU/WB_IMM8 encodings
  - FSM state constants
  - control-word bit index constants (FW_STU, FW_EN, FW_MEM, FW_SRC)
- One sub-module, fwd_match: combinational entry compare that returns {hit, word} for one operand. It is instantiated for A and B.

## Test plan
- ADD r1 then ADD using r1 as rs → next EX cycle fwCntrlA=5'b01010, no stall.
- LBI r2 then a gap instruction, then consumer of r2 in rt → fwCntrlB=5'b01111.
- LD r3 then a consumer of r3 → stall_if_id=bubble_ex=1 for one cycle, fwCntrlA=0 during the bubble, then fwCntrlA=5'b01101.
- ST with rt=r4 right after an ALU write to r4 → fwCntrlB=5'b11010.
- Load-use hazard and branch_misprediction in the same cycle → flush_if_id=1, FSM to FLUSH, no LDSTALL; the next cycle returns to RUN.
- rst asserted in LDSTALL → next cycle all outputs 0 and tracker empty. With EX_FWD_EN undefined, ALU-producer back-to-back dependency → 1-cycle stall, then fwCntrlA=5'b01110.
